// File: rtl/tow_pkg.sv
// Shared constants for the tug-of-war game: CPU opponent FSM encoding, LFSR taps,
// difficulty levels and the reaction-delay helper.
package tow_pkg;

    localparam int CNT_W = 12;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_PRESS = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam logic [1:0] DIFF_EASY   = 2'd0;
    localparam logic [1:0] DIFF_MEDIUM = 2'd1;
    localparam logic [1:0] DIFF_TRICKY = 2'd2;
    localparam logic [1:0] DIFF_HARD   = 2'd3;

    // Harder levels shrink both the base delay and the jitter span.
    function automatic logic [CNT_W-1:0] reaction_delay(
        input logic [7:0] base,
        input logic [1:0] diff,
        input logic [7:0] rnd,
        input logic       jitter_en
    );
        logic [CNT_W-1:0] scaled;
        logic [CNT_W-1:0] jitter;
        scaled = CNT_W'(base) << (2'd3 - diff);
        jitter = jitter_en ? CNT_W'(rnd >> diff) : '0;
        return scaled + jitter;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; also intended as the noise source for audio.
module lfsr16
    import tow_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    // An all-zero state would lock the register up, so a zero seed becomes 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= SEED_EFF;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/cpu_player.sv
// Computer opponent: on the lights-on cue, waits a difficulty-scaled pseudo-random
// delay and then emits a human-shaped press pulse for the right-player button.
module cpu_player
    import tow_pkg::*;
#(
    parameter int unsigned BASE_DELAY  = 20,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned RANDOM_EN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] difficulty,
    input  logic       leds_on,
    input  logic       clr,
    output logic       press,
    output logic       busy,
    output logic [7:0] press_count
);

    localparam logic [7:0] BASE8   = 8'(BASE_DELAY);
    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);
    localparam logic       JIT_EN  = (RANDOM_EN != 0);

    logic [15:0]      lfsr_value;
    logic             lfsr_unused;
    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       hcnt, hcnt_nx;
    logic             press_nx;
    logic [7:0]       count_nx;
    logic             leds_on_q;
    logic             rise;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_value)
    );

    assign lfsr_unused = ^lfsr_value[15:8];
    assign rise        = leds_on & ~leds_on_q;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hcnt_nx  = hcnt;
        press_nx = press;
        count_nx = press_count;
        if (!enable) begin
            state_nx = ST_IDLE;
            press_nx = 1'b0;
        end else begin
            case (state)
                ST_IDLE: state_nx = ST_ARMED;
                ST_ARMED: begin
                    if (rise && !clr) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = reaction_delay(BASE8, difficulty, lfsr_value[7:0], JIT_EN);
                    end
                end
                // Lights going out while waiting means the human already won.
                ST_WAIT: begin
                    if (clr || !leds_on) begin
                        state_nx = ST_ARMED;
                    end else if (cnt == '0) begin
                        state_nx = ST_PRESS;
                        hcnt_nx  = HOLD_M1;
                        press_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (clr) begin
                        state_nx = ST_ARMED;
                        press_nx = 1'b0;
                    end else if (hcnt == 4'd0) begin
                        state_nx = ST_DONE;
                        press_nx = 1'b0;
                        if (press_count != 8'hFF) count_nx = press_count + 8'd1;
                    end else begin
                        hcnt_nx = hcnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!leds_on) state_nx = ST_ARMED;
                end
                default: begin
                    state_nx = ST_IDLE;
                    press_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hcnt        <= 4'd0;
            press       <= 1'b0;
            busy        <= 1'b0;
            press_count <= 8'd0;
            leds_on_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            hcnt        <= hcnt_nx;
            press       <= press_nx;
            busy        <= (state_nx == ST_WAIT) || (state_nx == ST_PRESS);
            press_count <= count_nx;
            leds_on_q   <= leds_on;
        end
    end

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player: a deterministic and a randomised instance share
// stimulus; expected press windows come from the delay formula and a reference LFSR.
module tb_cpu_player;

    localparam int          BASE = 20;
    localparam int          HOLD = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] MASK = 16'hB400;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       leds_on = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] difficulty = 2'd3;
    logic       press_d, busy_d, press_r, busy_r;
    logic [7:0] count_d, count_r;

    int cyc = 0;
    int rst_edge = 0;
    int vectors = 0;
    int miscompares = 0;
    int cnt_d = 0;
    int cnt_r = 0;

    cpu_player #(.BASE_DELAY(BASE), .HOLD_CYCLES(HOLD), .LFSR_SEED(SEED), .RANDOM_EN(0)) dut_det (
        .clk(clk), .rst(rst), .enable(enable), .difficulty(difficulty), .leds_on(leds_on),
        .clr(clr), .press(press_d), .busy(busy_d), .press_count(count_d)
    );

    cpu_player #(.BASE_DELAY(BASE), .HOLD_CYCLES(HOLD), .LFSR_SEED(SEED), .RANDOM_EN(1)) dut_rnd (
        .clk(clk), .rst(rst), .enable(enable), .difficulty(difficulty), .leds_on(leds_on),
        .clr(clr), .press(press_r), .busy(busy_r), .press_count(count_r)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    // Value the LFSR holds after k advances from the seed.
    function automatic logic [15:0] lfsr_after(input int k);
        logic [15:0] v;
        v = SEED;
        for (int i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ MASK) : (v >> 1);
        return v;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    // Cue sampled at edge t, delay d: press is high after edges t+d+1 .. t+d+HOLD.
    function automatic logic press_exp(input int e, input int t, input int d);
        return (e >= t + d + 1) && (e < t + d + 1 + HOLD);
    endfunction

    function automatic logic busy_exp(input int e, input int t, input int d);
        return (e >= t) && (e < t + d + 1 + HOLD);
    endfunction

    // One full cue/press round; checks both instances every cycle and the counts after.
    task automatic do_round(input logic [1:0] diff, input string tag);
        int t, dd, dr;
        logic [15:0] lv;
        logic [3:0] exp_v;
        difficulty = diff;
        leds_on = 1'b0;
        clr = 1'b0;
        tick();
        tick();
        leds_on = 1'b1;
        t  = cyc + 1;
        lv = lfsr_after(t - rst_edge - 1);
        dd = BASE << (3 - int'(diff));
        dr = dd + int'(lv[7:0] >> diff);
        while (cyc < t + dr + HOLD + 2) begin
            tick();
            exp_v = {press_exp(cyc, t, dd), busy_exp(cyc, t, dd), press_exp(cyc, t, dr), busy_exp(cyc, t, dr)};
            vectors++;
            if ({press_d, busy_d, press_r, busy_r} !== exp_v) begin
                miscompares++;
                $display("FAIL %s edge %0d (cue %0d, D %0d/%0d): press/busy det,rnd = %b, expected %b",
                         tag, cyc - t, t, dd, dr, {press_d, busy_d, press_r, busy_r}, exp_v);
            end
        end
        cnt_d = sat_inc(cnt_d);
        cnt_r = sat_inc(cnt_r);
        vectors++;
        if ({count_d, count_r} !== {8'(cnt_d), 8'(cnt_r)}) begin
            miscompares++;
            $display("FAIL %s press_count det,rnd = %0d,%0d, expected %0d,%0d", tag, count_d, count_r, cnt_d, cnt_r);
        end
        leds_on = 1'b0;
    endtask

    // Expect both instances quiet for n cycles and counts unchanged.
    task automatic expect_quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            vectors++;
            if ({press_d, busy_d, press_r, busy_r} !== 4'b0000) begin
                miscompares++;
                $display("FAIL %s cycle %0d: press/busy det,rnd = %b, expected 0000", tag, i, {press_d, busy_d, press_r, busy_r});
            end
        end
        vectors++;
        if ({count_d, count_r} !== {8'(cnt_d), 8'(cnt_r)}) begin
            miscompares++;
            $display("FAIL %s press_count det,rnd = %0d,%0d, expected %0d,%0d", tag, count_d, count_r, cnt_d, cnt_r);
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        rst = 1'b0;
        leds_on = 1'b0;
        clr = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({press_d, busy_d, count_d, press_r, busy_r, count_r} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset outputs det=%b/%b/%0d rnd=%b/%b/%0d, expected all 0",
                     press_d, busy_d, count_d, press_r, busy_r, count_r);
        end
        rst_edge = cyc;
        rst = 1'b1;
        cnt_d = 0;
        cnt_r = 0;
        expect_quiet(3, "reset_idle");
    endtask

    task automatic test_hard();
        do_round(2'd3, "hard");
    endtask

    task automatic test_easy();
        do_round(2'd0, "easy");
    endtask

    task automatic test_abort();
        int t;
        difficulty = 2'd3;
        leds_on = 1'b0;
        tick();
        tick();
        leds_on = 1'b1;
        t = cyc + 1;
        while (cyc < t + 9) tick();
        vectors++;
        if ({press_d, busy_d, press_r, busy_r} !== 4'b0101) begin
            miscompares++;
            $display("FAIL abort_waiting press/busy det,rnd = %b, expected 0101", {press_d, busy_d, press_r, busy_r});
        end
        leds_on = 1'b0;
        expect_quiet(40, "abort");
        do_round(2'd3, "abort_retrigger");
    endtask

    task automatic test_missed_cue();
        enable = 1'b0;
        leds_on = 1'b0;
        tick();
        leds_on = 1'b1;
        tick();
        tick();
        enable = 1'b1;
        expect_quiet(40, "missed_cue");
        do_round(2'd2, "after_missed_cue");
    endtask

    task automatic test_disable_wait();
        int t;
        difficulty = 2'd3;
        leds_on = 1'b0;
        tick();
        tick();
        leds_on = 1'b1;
        t = cyc + 1;
        while (cyc < t + 4) tick();
        enable = 1'b0;
        expect_quiet(40, "disable_in_wait");
        enable = 1'b1;
        do_round(2'd3, "after_disable");
    endtask

    // Only the deterministic instance has a known press window here.
    task automatic test_clear_press();
        int t, p;
        difficulty = 2'd3;
        leds_on = 1'b0;
        tick();
        tick();
        leds_on = 1'b1;
        t = cyc + 1;
        p = t + BASE + 1;
        while (cyc < p + 1) tick();
        vectors++;
        if (press_d !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_second_press_cycle press = %b, expected 1", press_d);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if ({press_d, busy_d} !== 2'b00) begin
            miscompares++;
            $display("FAIL clear_press_drop press/busy = %b, expected 00", {press_d, busy_d});
        end
        repeat (HOLD + 2) tick();
        vectors++;
        if ({press_d, count_d} !== {1'b0, 8'(cnt_d)}) begin
            miscompares++;
            $display("FAIL clear_no_count press=%b count=%0d, expected press 0 count %0d", press_d, count_d, cnt_d);
        end
        leds_on = 1'b0;
    endtask

    task automatic test_reset_mid_press();
        int t;
        difficulty = 2'd3;
        leds_on = 1'b0;
        tick();
        tick();
        leds_on = 1'b1;
        t = cyc + 1;
        while (cyc < t + BASE + 1) tick();
        vectors++;
        if (press_d !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_press_setup press = %b, expected 1", press_d);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({press_d, busy_d, count_d, press_r, busy_r, count_r} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_mid_press det=%b/%b/%0d rnd=%b/%b/%0d, expected all 0",
                     press_d, busy_d, count_d, press_r, busy_r, count_r);
        end
        leds_on = 1'b0;
        tick();
        tick();
        rst_edge = cyc;
        rst = 1'b1;
        cnt_d = 0;
        cnt_r = 0;
    endtask

    task automatic test_random_saturation();
        for (int i = 0; i < 300; i++) do_round(2'($urandom_range(1, 3)), "random_round");
        vectors++;
        if ({count_d, count_r} !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL saturation press_count det,rnd = %0d,%0d, expected 255,255", count_d, count_r);
        end
    endtask

    initial begin
        test_reset();
        test_hard();
        test_easy();
        test_abort();
        test_missed_cue();
        test_disable_wait();
        test_clear_press();
        test_reset_mid_press();
        test_random_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
